// File: rtl/core_pkg.sv
// Shared definitions for the instruction prefetch buffer: default widths,
// fetch FSM states and the occupancy/in-flight counter width.
package core_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Counters must represent the full range 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs with push/pop/clear and
// an occupancy count. Storage is not reset; only pointers and count are.
module if_fifo
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_instr,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_instr,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [XLEN-1:0]  r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    // Clear wins over push and pop so a flush always leaves the FIFO empty.
    assign w_wr_en = i_push && !i_clear;
    assign w_rd_en = i_pop && !i_clear && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_pc_mem[r_wr_ptr]    <= i_pc;
            r_instr_mem[r_wr_ptr] <= i_instr;
        end
    end

    assign o_pc    = r_pc_mem[r_rd_ptr];
    assign o_instr = r_instr_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch buffer: in-order word fetch, DEPTH-entry buffer, flush/drain.
// Optional IF_MISALIGN_CHK_EN adds misalign_err, flagging a flush target with bits[1:0]!=0.
module if_prefetch
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
`ifdef IF_MISALIGN_CHK_EN
    output logic            misalign_err,
`endif
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] addr_instr
);

    localparam int              CNT_W     = cnt_width(DEPTH);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rsp_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_drop;
    logic             r_req_valid;
    logic [CNT_W-1:0] w_inflight_nxt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_count;
    logic             w_req_valid_nxt;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_flush_pc;
    logic [XLEN-1:0]  w_fifo_pc;
    logic [XLEN-1:0]  w_fifo_instr;
`ifdef IF_MISALIGN_CHK_EN
    logic             r_misalign_err;
`endif

    assign w_accept   = r_req_valid && mem_req_ready;
    assign w_push     = mem_rsp_valid && (r_state == FETCH) && !flush;
    assign w_pop      = instr_valid && instr_ready && !flush;
    assign w_flush_pc = flush_pc & WORD_MASK;

    // Request valid is registered from next-cycle occupancy so every issued
    // request is guaranteed a free FIFO slot when its response returns.
    always_comb begin
        w_inflight_nxt = r_inflight + CNT_W'(w_accept) - CNT_W'(mem_rsp_valid);
        w_occ_nxt      = flush ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
        w_state_nxt    = r_state;
        if (flush) begin
            w_state_nxt = (w_inflight_nxt != '0) ? DRAIN : FETCH;
        end else if ((r_state == DRAIN) && mem_rsp_valid && (r_drop == CNT_W'(1))) begin
            w_state_nxt = FETCH;
        end
        w_req_valid_nxt = (w_state_nxt == FETCH) &&
                          (({1'b0, w_occ_nxt} + {1'b0, w_inflight_nxt}) < (CNT_W+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_inflight  <= '0;
            r_drop      <= '0;
            r_req_valid <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            r_misalign_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_inflight  <= w_inflight_nxt;
            r_req_valid <= w_req_valid_nxt;
            if (flush) begin
                // Responses are in order, so the next kept response is the flush target.
                r_pc     <= w_flush_pc;
                r_rsp_pc <= w_flush_pc;
                r_drop   <= w_inflight_nxt;
`ifdef IF_MISALIGN_CHK_EN
                r_misalign_err <= (flush_pc[1:0] != 2'b00);
`endif
            end else begin
                if (w_accept) r_pc <= r_pc + XLEN'(4);
                if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(4);
                if ((r_state == DRAIN) && mem_rsp_valid) r_drop <= r_drop - CNT_W'(1);
            end
        end
    end

    if_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_pc    (r_rsp_pc),
        .i_instr (mem_rsp_data),
        .o_pc    (w_fifo_pc),
        .o_instr (w_fifo_instr),
        .o_count (w_count)
    );

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_pc;
    assign instr_valid   = (w_count != '0);
    assign instr_out     = instr_valid ? w_fifo_instr : '0;
    assign addr_instr    = instr_valid ? w_fifo_pc : '0;
`ifdef IF_MISALIGN_CHK_EN
    assign misalign_err  = r_misalign_err;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: memory model with configurable latency, scoreboard of
// expected {pc, instr} pairs, flush-target vector table and corner-case sequences.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] addr_instr;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    if_prefetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .flush         (flush),
        .flush_pc      (flush_pc),
`ifdef IF_MISALIGN_CHK_EN
        .misalign_err  (misalign_err),
`endif
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .addr_instr    (addr_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        mis;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          n_acc = 0;
    int          first_acc = -1;
    int          first_vld = -1;
    logic [31:0] last_acc = '0;
    logic [31:0] exp_req_pc = '0;
    req_t        pend[$];
    req_t        cur;
    logic [31:0] sb[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory model and scoreboard: sample at the edge, drive responses 1ns later.
    always @(posedge clk) begin
        logic        stale;
        logic [31:0] e;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            sb.delete();
            exp_req_pc = 32'h0;
            epoch      = 0;
            n_acc      = 0;
            first_acc  = -1;
            first_vld  = -1;
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end else begin
            stale = 1'b0;
            foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1'b1;
            if (mem_rsp_valid && (cur.epoch != epoch)) stale = 1'b1;
            if (stale) chk("no_req_in_drain", {31'b0, mem_req_valid}, 32'd0);
            if (instr_valid && (first_vld < 0)) first_vld = cyc;
            if (instr_valid && instr_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL pop_unexpected: got addr_instr %h expected no instruction", addr_instr);
                end else begin
                    e = sb.pop_front();
                    chk("addr_instr", addr_instr, e);
                    chk("instr_out", instr_out, mem_fn(e));
                end
                pop_log.push_back(addr_instr);
            end
            if (mem_rsp_valid && !flush && (cur.epoch == epoch)) sb.push_back(cur.addr);
            if (mem_req_valid && mem_req_ready) begin
                chk("req_addr", mem_req_addr, exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
                pend.push_back('{addr: mem_req_addr, epoch: epoch, due: cyc + lat - 1});
                n_acc++;
                last_acc = mem_req_addr;
                if (first_acc < 0) first_acc = cyc;
            end
            if (flush) begin
                epoch++;
                sb.delete();
                exp_req_pc = flush_pc & ~32'h3;
            end
            #1;
            if ((pend.size() != 0) && (pend[0].due <= cyc)) begin
                cur           = pend.pop_front();
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_fn(cur.addr);
            end else begin
                mem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic rdy);
        rst_n       = 1'b0;
        flush       = 1'b0;
        instr_ready = rdy;
        repeat (3) tick();
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_addr_instr", addr_instr, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    task automatic wait_pops(input int n, input string nm);
        for (int i = 0; i < 60 && pop_log.size() < n; i++) tick();
        chk(nm, {31'b0, pop_log.size() >= n}, 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int s;
        vecs[0] = '{fpc: 32'h0000_0102, a0: 32'h0000_0100, a1: 32'h0000_0104, mis: 1'b1};
        vecs[1] = '{fpc: 32'h0000_0200, a0: 32'h0000_0200, a1: 32'h0000_0204, mis: 1'b0};
        vecs[2] = '{fpc: 32'hFFFF_FFFC, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000, mis: 1'b0};
        vecs[3] = '{fpc: 32'hFFFF_FFFF, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000, mis: 1'b1};
        vecs[4] = '{fpc: 32'h0000_0040, a0: 32'h0000_0040, a1: 32'h0000_0044, mis: 1'b0};

        // Streaming with 1-cycle memory: latency and throughput.
        lat           = 1;
        mem_req_ready = 1'b1;
        do_reset(1'b1);
        pop_log.delete();
        wait_pops(4, "t1_first_pops");
        if (pop_log.size() != 0) chk("t1_first_addr", pop_log[0], 32'h0);
        chk("t1_latency", first_vld - first_acc, 32'd2);
        s = pop_log.size();
        repeat (10) tick();
        chk("t1_throughput", pop_log.size() - s, 32'd10);

        // Core stalled: buffer fills, requests stop at DEPTH.
        do_reset(1'b0);
        repeat (15) tick();
        chk("t2_acc_count", n_acc, 32'd4);
        chk("t2_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("t2_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_head_addr", addr_instr, 32'h0);
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 5; i++) tick();
        chk("t2_resume_addr", last_acc, 32'h10);

        // Flush with two requests in flight on a 3-cycle memory.
        lat           = 3;
        mem_req_ready = 1'b0;
        do_reset(1'b1);
        repeat (3) tick();
        chk("t3_req_valid", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        tick();
        tick();
        chk("t3_inflight", n_acc, 32'd2);
        mem_req_ready = 1'b0;
        flush         = 1'b1;
        flush_pc      = 32'h0000_0100;
        pop_log.delete();
        tick();
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        chk("t3_vld_after_flush", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("t3_no_req_drain", {31'b0, mem_req_valid}, 32'd0);
        wait_pops(1, "t3_pop");
        if (pop_log.size() != 0) chk("t3_first_addr", pop_log[0], 32'h100);

        // Flush coinciding with a pop and a response.
        lat = 1;
        do_reset(1'b1);
        repeat (8) tick();
        chk("t4_pre", {30'b0, instr_valid, mem_rsp_valid}, 32'd3);
        flush    = 1'b1;
        flush_pc = 32'h0000_0200;
        pop_log.delete();
        tick();
        flush = 1'b0;
        chk("t4_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_addr_instr", addr_instr, 32'h0);
        wait_pops(1, "t4_pop");
        if (pop_log.size() != 0) chk("t4_first_addr", pop_log[0], 32'h200);

        // Flush target table, including wrap and misaligned targets.
        for (int v = 0; v < 5; v++) begin
            flush    = 1'b1;
            flush_pc = vecs[v].fpc;
            pop_log.delete();
            tick();
            flush = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            chk("vec_misalign", {31'b0, misalign_err}, {31'b0, vecs[v].mis});
`endif
            wait_pops(2, "vec_pops");
            if (pop_log.size() >= 2) begin
                chk("vec_addr0", pop_log[0], vecs[v].a0);
                chk("vec_addr1", pop_log[1], vecs[v].a1);
            end
            repeat (3) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
